// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU.
// Build option: define ALU_SEQ_DIV_EN to implement DIVU/REMU with the iterative divider.
package alu_seq_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_MUL  = 3'b100,
    OP_SLT  = 3'b101,
    OP_DIVU = 3'b110,
    OP_REMU = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Ops that go through the shared iterative datapath.
  function automatic logic is_multi(op_e op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Build option: ALU_SEQ_DIV_EN adds the divide step; otherwise only MUL is supported.
// start loads operands; done is high during the final step and result is the
// value that step produces, so the parent captures it on the same edge.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic             busy;
  logic [CW-1:0]    cnt;
  op_e              op_q;
  // x: multiplicand (MUL) or dividend/quotient shifter (DIV)
  // y: multiplier (MUL) or divisor (DIV)
  // acc: product (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] x, y, acc;
  logic [WIDTH-1:0] x_n, y_n, acc_n;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] diff;
  logic             ge;
`endif

  assign done = busy && (cnt == CW'(WIDTH - 1));

  // One iteration step of the selected operation, plus result selection.
  always_comb begin
    x_n    = x;
    y_n    = y;
    acc_n  = acc;
    result = '0;
`ifdef ALU_SEQ_DIV_EN
    r    = {acc, x[WIDTH-1]};
    ge   = (r >= {1'b0, y});
    diff = r[WIDTH-1:0] - y;
`endif
    case (op_q)
      OP_MUL: begin
        if (y[0]) acc_n = acc + x;
        x_n    = x << 1;
        y_n    = y >> 1;
        result = acc_n;
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU, OP_REMU: begin
        // Remainder stays below the divisor, so r - y fits WIDTH bits when ge.
        acc_n  = ge ? diff : r[WIDTH-1:0];
        x_n    = {x[WIDTH-2:0], ge};
        result = (op_q == OP_DIVU) ? x_n : acc_n;
      end
`endif
      default: result = '0;
    endcase
  end

  // Operand load on start, then one step per cycle for WIDTH cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= OP_MUL;
      x    <= '0;
      y    <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      op_q <= op;
      x    <= a;
      y    <= b;
      acc  <= '0;
    end else if (busy) begin
      x   <= x_n;
      y   <= y_n;
      acc <= acc_n;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready handshake, IDLE/BUSY/DONE FSM, registered result and flags.
// Build option: ALU_SEQ_DIV_EN enables DIVU/REMU; without it they complete in one
// cycle with ALU_Out = 0 and overflow = 1.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  state_e           state_q, state_d;
  op_e              op;
  logic             accept, multi;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;
`ifdef ALU_SEQ_DIV_EN
  logic             dz_q;
`endif

  assign op        = op_e'(ALU_Sel);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign multi     = is_multi(op);

  // Single-cycle ops evaluated straight from the inputs at the accept edge.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_ext = {1'b0, A} + {1'b0, B};
    dif_ext = {1'b0, A} - {1'b0, B};
    case (op)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = ~dif_ext[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
`ifndef ALU_SEQ_DIV_EN
      OP_DIVU, OP_REMU: alu_v = 1'b1;
`endif
      default: alu_res = '0;
    endcase
  end

  alu_seq_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && multi),
    .op    (op),
    .a     (A),
    .b     (B),
    .done  (iter_done),
    .result(iter_res)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = multi ? S_BUSY : S_DONE;
      S_BUSY: if (iter_done) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result and flag registers, loaded at single-cycle accept or final iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALU_Out  <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      dz_q     <= 1'b0;
`endif
    end else if (accept && !multi) begin
      ALU_Out  <= alu_res;
      zero     <= (alu_res == '0);
      negative <= alu_res[WIDTH-1];
      carry    <= alu_c;
      overflow <= alu_v;
    end else if (accept) begin
`ifdef ALU_SEQ_DIV_EN
      dz_q <= (op != OP_MUL) && (B == '0);
`endif
    end else if ((state_q == S_BUSY) && iter_done) begin
      ALU_Out  <= iter_res;
      zero     <= (iter_res == '0);
      negative <= iter_res[WIDTH-1];
      carry    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      overflow <= dz_q;
`else
      overflow <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32) against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [2:0]    ALU_Sel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  ALU_Out;
  logic          zero, negative, carry, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALU_Out  (ALU_Out),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic.
  task automatic model(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] o, output logic z, output logic n,
                       output logic c, output logic v, output int lat);
    longint sa, sb, s;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    o = '0; c = 1'b0; v = 1'b0; lat = 1;
    case (sel)
      3'd0: begin
        u = 64'(a) + 64'(b); o = u[W-1:0]; c = u[W];
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        o = a - b; c = (a >= b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: begin u = 64'(a) * 64'(b); o = u[W-1:0]; lat = W + 1; end
      3'd5: o = (sa < sb) ? 32'd1 : 32'd0;
      default: begin
`ifdef ALU_SEQ_DIV_EN
        lat = W + 1;
        if (b == 0) begin
          o = (sel == 3'd6) ? 32'hFFFF_FFFF : a;
          v = 1'b1;
        end else begin
          o = (sel == 3'd6) ? a / b : a % b;
        end
`else
        o = '0; v = 1'b1;
`endif
      end
    endcase
    z = (o == 0);
    n = o[W-1];
  endtask

  // Issue one op, measure latency, hold the result for 'hold' cycles with
  // in_valid noise, then release it and confirm the return to IDLE.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] eo;
    logic ez, en, ec, ev;
    int el, lat;
    model(sel, a, b, eo, ez, en, ec, ev, el);
    @(negedge clk);
    chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    A = a; B = b; ALU_Sel = sel; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; A = $urandom; B = $urandom; ALU_Sel = 3'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat <= W + 5) begin
      chk({tag, " in_ready_busy"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(el));
    for (int k = 0; k <= hold; k++) begin
      chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " in_ready_done"}, 64'(in_ready), 64'd0);
      chk({tag, " ALU_Out"}, 64'(ALU_Out), 64'(eo));
      chk({tag, " flags"}, 64'({zero, negative, carry, overflow}), 64'({ez, en, ec, ev}));
      if (k < hold) begin
        in_valid = 1'($urandom);
        A = $urandom; B = $urandom; ALU_Sel = 3'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " released_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " released_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0] rs;
    logic [2:0] long_op;

    // Reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst ALU_Out", 64'(ALU_Out), 64'd0);
    chk("rst flags", 64'({zero, negative, carry, overflow}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst release in_ready", 64'(in_ready), 64'd1);

    // Directed corners
    run_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("add_carry", 3'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub_eq", 3'd1, 32'd5, 32'd5, 0);
    run_op("sub_borrow", 3'd1, 32'd0, 32'd1, 0);
    run_op("sub_ovf", 3'd1, 32'h8000_0000, 32'd1, 0);
    run_op("slt_neg", 3'd5, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt_pos", 3'd5, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("and", 3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_op("or", 3'd3, 32'hF000_0000, 32'h0000_000F, 0);
    run_op("mul", 3'd4, 32'h0001_0000, 32'h0001_0001, 0);
    run_op("mul_ones", 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("divu", 3'd6, 32'd100, 32'd7, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 0);
    run_op("divu_z", 3'd6, 32'd100, 32'd0, 0);
    run_op("remu_z", 3'd7, 32'h8000_0001, 32'd0, 0);
    run_op("hold", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);

    // Randomized ops with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      rs = 3'($urandom);
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'd1;
        2: rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op("rand", rs, ra, rb, $urandom_range(0, 2));
    end

    // Reset in the middle of a long operation
`ifdef ALU_SEQ_DIV_EN
    long_op = 3'd6;
`else
    long_op = 3'd4;
`endif
    @(negedge clk);
    A = 32'd100; B = 32'd7; ALU_Sel = long_op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst ALU_Out", 64'(ALU_Out), 64'd0);
    chk("midrst flags", 64'({zero, negative, carry, overflow}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 40; k++) begin
      chk("midrst stray_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    run_op("after_rst", 3'd0, 32'd3, 32'd4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
